multibyte_add_seq: RTL and testbench

//  Sequences the registered 8-bit full adder (full_adder_8bit) to add two NBYTES-wide operands, one byte per slot.
//  The carry ripples from byte 0 (LSB) upward.

---
 rtl/multibyte_add_seq_if.sv | 34 +++
 rtl/multibyte_add_seq.sv | 134 +++++++++++++
 tb/tb_multibyte_add_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multibyte_add_seq_if.sv
// Bundle between the multi-byte add sequencer, its operand source, result sink and the 8-bit adder.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid holds until then.
interface multibyte_add_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         result_co;
  logic         busy;
  logic [7:0]   add_A;
  logic [7:0]   add_B;
  logic         add_C_in;
  logic [7:0]   add_SUM;
  logic         add_C_out;
  logic [1:0]   state;

  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready, add_SUM, add_C_out,
    output in_ready, out_valid, result, result_co, busy, add_A, add_B, add_C_in, state
  );

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready, add_SUM, add_C_out,
    input  in_ready, out_valid, result, result_co, busy, add_A, add_B, add_C_in, state
  );
endinterface

// File: rtl/multibyte_add_seq.sv
// Drives one registered 8-bit adder byte by byte to add two NBYTES-wide operands,
// rippling the carry from byte 0 upward; every output is a flop.
module multibyte_add_seq #(
  parameter int NBYTES  = 4,
  parameter int ADD_LAT = 2
) (
  input logic                Clock,
  input logic                Reset_n,
  multibyte_add_seq_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t       state_q, state_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [SW-1:0] slot_q, slot_n;
  logic [W-1:0] a_q, a_n, b_q, b_n, result_q, result_n;
  logic         co_q, co_n;
  logic         in_ready_q, in_ready_n;
  logic         out_valid_q, out_valid_n;
  logic         busy_q, busy_n;
  logic [7:0]   add_a_q, add_a_n, add_b_q, add_b_n;
  // add_cin_q doubles as the inter-byte carry register.
  logic         add_cin_q, add_cin_n;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      slot_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      co_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      slot_q      <= slot_n;
      a_q         <= a_n;
      b_q         <= b_n;
      result_q    <= result_n;
      co_q        <= co_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      busy_q      <= busy_n;
      add_a_q     <= add_a_n;
      add_b_q     <= add_b_n;
      add_cin_q   <= add_cin_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    slot_n      = slot_q;
    a_n         = a_q;
    b_n         = b_q;
    result_n    = result_q;
    co_n        = co_q;
    in_ready_n  = in_ready_q;
    out_valid_n = out_valid_q;
    busy_n      = busy_q;
    add_a_n     = add_a_q;
    add_b_n     = add_b_q;
    add_cin_n   = add_cin_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_n        = bus.op_a;
          b_n        = bus.op_b;
          idx_n      = '0;
          slot_n     = '0;
          add_a_n    = bus.op_a[7:0];
          add_b_n    = bus.op_b[7:0];
          add_cin_n  = bus.op_cin;
          in_ready_n = 1'b0;
          busy_n     = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        // The adder output is only trusted on the last edge of a slot.
        if (slot_q == SW'(ADD_LAT)) begin
          result_n[{idx_q, 3'b000} +: 8] = bus.add_SUM;
          slot_n = '0;
          if (idx_q == IW'(NBYTES - 1)) begin
            co_n        = bus.add_C_out;
            idx_n       = '0;
            add_a_n     = '0;
            add_b_n     = '0;
            add_cin_n   = 1'b0;
            out_valid_n = 1'b1;
            state_n     = DONE;
          end else begin
            idx_n     = idx_q + IW'(1);
            add_a_n   = a_q[{idx_n, 3'b000} +: 8];
            add_b_n   = b_q[{idx_n, 3'b000} +: 8];
            add_cin_n = bus.add_C_out;
          end
        end else begin
          slot_n = slot_q + SW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_co = co_q;
  assign bus.busy      = busy_q;
  assign bus.add_A     = add_a_q;
  assign bus.add_B     = add_b_q;
  assign bus.add_C_in  = add_cin_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq: behavioural registered 8-bit adder, vector table, corner sequences
// and a queue scoreboard fed at accept time and drained when results are handed off.
module tb_multibyte_add_seq;
  localparam int NBYTES  = 4;
  localparam int ADD_LAT = 2;
  localparam int W       = 8 * NBYTES;
  localparam int LAT     = NBYTES * (ADD_LAT + 1);

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         co;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic prev_valid = 1'b0;
  logic [W:0] exp_q[$];
  int         acc_q[$];
  logic [W:0] exp_pop;
  int         acc_pop;
  vec_t       vecs[7];
  logic [8:0] pipe[ADD_LAT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multibyte_add_seq_if #(.NBYTES(NBYTES)) bus();

  multibyte_add_seq #(.NBYTES(NBYTES), .ADD_LAT(ADD_LAT)) dut (
    .Clock  (clk),
    .Reset_n(rst_n),
    .bus    (bus.slave)
  );

  // Unreset registered adder with exactly ADD_LAT edges of latency.
  always @(posedge clk) begin
    pipe[0] <= {1'b0, bus.add_A} + {1'b0, bus.add_B} + {8'd0, bus.add_C_in};
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.add_SUM   = pipe[ADD_LAT-1][7:0];
  assign bus.add_C_out = pipe[ADD_LAT-1][8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Scoreboard: latency measured at out_valid rise, data compared at the hand-off cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        else begin
          acc_pop = acc_q.pop_front();
          check("latency", 64'(cyc - acc_pop), 64'(LAT));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'(bus.out_valid), 64'd0);
        else begin
          exp_pop = exp_q.pop_front();
          check("result", 64'({bus.result_co, bus.result}), 64'(exp_pop));
        end
      end
    end
    prev_valid = bus.out_valid;
  end

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W:0] exp, input bit push, output int acc);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_cin   = cin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc = cyc;
    if (push) begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_result"}, 64'({bus.result_co, bus.result}), 64'd0);
    check({tag, "_adder_drive"}, 64'({bus.add_A, bus.add_B, bus.add_C_in}), 64'd0);
    check({tag, "_state"}, 64'(bus.state), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc;
    logic [3:0]   t3_cin;
    logic [W-1:0] t3_a, sh;
    logic [W-1:0] ra, rb;
    logic         rc;
    int n;

    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_cin    = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h0000_0008, 32'h0000_000F, 1'b1, 32'h0000_0018, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, back to back with the sink always ready.
    prev_acc = 0;
    for (int i = 0; i < 7; i++) begin
      drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].co, vecs[i].res}, 1'b1, acc);
      if (i > 0) check("accept_spacing", 64'(acc - prev_acc), 64'(LAT + 2));
      prev_acc = acc;
    end
    wait_drain();

    // Per-slot adder drive for 0x00FF00FF + 0x00010001.
    t3_a   = 32'h00FF_00FF;
    t3_cin = 4'b1010;
    drive_op(t3_a, 32'h0001_0001, 1'b0, {1'b0, 32'h0100_0100}, 1'b1, acc);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      sh = t3_a >> (8 * (k / (ADD_LAT + 1)));
      check("t3_add_C_in", 64'(bus.add_C_in), 64'(t3_cin[k / (ADD_LAT + 1)]));
      check("t3_add_A", 64'(bus.add_A), 64'(sh[7:0]));
    end
    @(negedge clk);
    check("t3_done_valid", 64'(bus.out_valid), 64'd1);
    check("t3_done_drive", 64'({bus.add_A, bus.add_B, bus.add_C_in}), 64'd0);
    wait_drain();

    // Backpressure, with a competing request held during DONE.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 32'h2345_6789}, 1'b1, acc);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_out_valid_seen", 64'(bus.out_valid), 64'd1);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op_a     = 32'h0000_0005;
      bus.op_b     = 32'h0000_0007;
      bus.op_cin   = 1'b0;
      @(negedge clk);
      check("t4_result_held", 64'({bus.result_co, bus.result}), 64'h0_2345_6789);
      check("t4_in_ready_low", 64'(bus.in_ready), 64'd0);
      check("t4_out_valid_held", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_not_yet_accepted", 64'({bus.in_ready, bus.busy, bus.out_valid}), 64'b100);
    @(negedge clk);
    check("t4_accepted_next", 64'({bus.in_ready, bus.busy}), 64'b01);
    exp_q.push_back({1'b0, 32'h0000_000C});
    acc_q.push_back(cyc);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of the second byte slot.
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, '0, 1'b0, acc);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(32'h0000_0006, 32'h0000_000A, 1'b1, {1'b0, 32'h0000_0011}, 1'b1, acc);
    wait_drain();

    // Random operands against the arithmetic model.
    for (int r = 0; r < 4; r++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      drive_op(ra, rb, rc, model(ra, rb, rc), 1'b1, acc);
    end
    wait_drain();

    repeat (3) @(posedge clk);
    check("latency_queue_empty", 64'(acc_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
